mult_sweep_checker: RTL and testbench



---
 rtl/mult_eval_pkg.sv | 19 +
 rtl/mult_eval_pipe.sv | 36 +++
 rtl/mult_sweep_checker.sv | 133 +++++++++++++
 tb/tb_mult_sweep_checker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_eval_pkg.sv
// Shared types and sizing helpers for the multiplier sweep checker.
package mult_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic int vec_count(input int w);
    return 1 << (2 * w);
  endfunction

  function automatic int err_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/mult_eval_pipe.sv
// DEPTH-stage {valid, idx} delay line that tracks the latency of the multiplier under test.
module mult_eval_pipe #(
  parameter int unsigned IW    = 4,
  parameter int unsigned DEPTH = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  output logic          out_valid,
  output logic [IW-1:0] out_idx
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_valid = in_valid;
      assign out_idx   = in_idx;
    end else begin : g_shift
      logic [IW:0] sr [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
          sr[0] <= {in_valid, in_idx};
          for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign {out_valid, out_idx} = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mult_sweep_checker.sv
// Exhaustive sweep of all {A,B} operand pairs against a candidate multiplier.
// Define FAIL_MAP_EN to add the per-vector fail_map output.
module mult_sweep_checker
  import mult_eval_pkg::*;
#(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned DUT_LAT = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [WIDTH-1:0]            a_out,
  output logic [WIDTH-1:0]            b_out,
  input  logic [2*WIDTH-1:0]          p_in,
  output logic [err_w(WIDTH)-1:0]     err_count,
  output logic                        first_fail_valid,
  output logic [2*WIDTH-1:0]          first_fail_ab,
  output logic [2*WIDTH-1:0]          first_fail_p
`ifdef FAIL_MAP_EN
  ,
  output logic [vec_count(WIDTH)-1:0] fail_map
`endif
);

  localparam int unsigned N  = vec_count(WIDTH);
  localparam int unsigned IW = 2 * WIDTH;
  localparam int unsigned EW = err_w(WIDTH);
  localparam int unsigned CW = $clog2(DUT_LAT + 1) + 1;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  dcnt;
  logic           pv;
  logic [IW-1:0]  pidx;
  logic [IW-1:0]  pa, pb, exp_p;
  logic           mism;
  logic           accept;

  assign accept = (state == IDLE) && start;

  // idx is forced to 0 whenever the sweep is not in RUN, so operands idle at 0.
  assign a_out = idx[IW-1:WIDTH];
  assign b_out = idx[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      dcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            idx   <= '0;
          end
        end
        RUN: begin
          if (idx == IW'(N - 1)) begin
            idx  <= '0;
            dcnt <= '0;
            if (DUT_LAT == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt == CW'(DUT_LAT - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mult_eval_pipe #(
    .IW   (IW),
    .DEPTH(DUT_LAT)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (state == RUN),
    .in_idx   (idx),
    .out_valid(pv),
    .out_idx  (pidx)
  );

  assign pa    = IW'(pidx[IW-1:WIDTH]);
  assign pb    = IW'(pidx[WIDTH-1:0]);
  assign exp_p = pa * pb;
  assign mism  = pv && (p_in != exp_p);

  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_ab    <= '0;
      first_fail_p     <= '0;
`ifdef FAIL_MAP_EN
      fail_map         <= '0;
`endif
    end else if (mism) begin
      if (err_count != EW'(N)) err_count <= err_count + 1'b1;
      if (!first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_ab    <= pidx;
        first_fail_p     <= p_in;
      end
`ifdef FAIL_MAP_EN
      fail_map[pidx] <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mult_sweep_checker.sv
// Scoreboard bench for mult_sweep_checker with W=2, using DUT_LAT=0 and DUT_LAT=2 instances.
module tb_mult_sweep_checker;

  localparam int N = 16;

  typedef struct {
    logic [4:0]  err;
    logic        ffv;
    logic [3:0]  ffab;
    logic [3:0]  ffp;
    logic [15:0] map;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n, start0, start2;
  logic busy0, done0, ffv0, busy2, done2, ffv2;
  logic [1:0] a0, b0, a2, b2;
  logic [3:0] p0, p2, ffab0, ffp0, ffab2, ffp2;
  logic [4:0] err0, err2;
`ifdef FAIL_MAP_EN
  logic [15:0] map0, map2;
`endif

  mult_sweep_checker #(.WIDTH(2), .DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .a_out(a0), .b_out(b0), .p_in(p0), .err_count(err0),
    .first_fail_valid(ffv0), .first_fail_ab(ffab0), .first_fail_p(ffp0)
`ifdef FAIL_MAP_EN
    , .fail_map(map0)
`endif
  );

  mult_sweep_checker #(.WIDTH(2), .DUT_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .a_out(a2), .b_out(b2), .p_in(p2), .err_count(err2),
    .first_fail_valid(ffv2), .first_fail_ab(ffab2), .first_fail_p(ffp2)
`ifdef FAIL_MAP_EN
    , .fail_map(map2)
`endif
  );

  // Candidate multipliers: 0 exact, 1 tied to zero, 2 P[0] stuck low, 3 random table, 4 inverted.
  int mode0 = 0, mode2 = 0;
  bit dly0 = 1'b0;
  logic [3:0] lut [16];
  logic [3:0] r0a, r0b, r2a, r2b;

  function automatic logic [3:0] fdut(int mode, int k);
    logic [3:0] e;
    e = 4'((k / 4) * (k % 4));
    case (mode)
      1:       return 4'h0;
      2:       return e & 4'hE;
      3:       return lut[k];
      4:       return ~e;
      default: return e;
    endcase
  endfunction

  always @(posedge clk) begin
    r0a <= fdut(mode0, int'({a0, b0}));
    r0b <= r0a;
    r2a <= fdut(mode2, int'({a2, b2}));
    r2b <= r2a;
  end

  assign p0 = dly0 ? r0b : fdut(mode0, int'({a0, b0}));
  assign p2 = r2b;

  // Reference: walk all vectors; shift2 models a two-cycle DUT seen by a zero-latency checker.
  function automatic res_t model(int mode, bit shift2);
    res_t r;
    logic [3:0] obs, ex;
    r.err = 0; r.ffv = 0; r.ffab = 0; r.ffp = 0; r.map = 0;
    for (int k = 0; k < N; k++) begin
      obs = fdut(mode, shift2 ? ((k >= 2) ? k - 2 : 0) : k);
      ex  = 4'((k / 4) * (k % 4));
      if (obs != ex) begin
        if (r.err < 16) r.err = r.err + 1;
        if (!r.ffv) begin
          r.ffv = 1; r.ffab = 4'(k); r.ffp = obs;
        end
        r.map[k] = 1'b1;
      end
    end
    return r;
  endfunction

  int nchk = 0, nfail = 0;
  bit mon_en = 0;
  int s0 = -1, s2 = -1;
  res_t q0[$], q2[$];
  res_t last0;

  task automatic chk(string name, int act, int req);
    nchk++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_res(string tag, res_t e, logic [4:0] err, logic ffv,
                           logic [3:0] ab, logic [3:0] p, logic [15:0] map);
    chk({tag, ".err_count"}, int'(err), int'(e.err));
    chk({tag, ".first_fail_valid"}, int'(ffv), int'(e.ffv));
    chk({tag, ".first_fail_ab"}, int'(ab), int'(e.ffab));
    chk({tag, ".first_fail_p"}, int'(p), int'(e.ffp));
`ifdef FAIL_MAP_EN
    chk({tag, ".fail_map"}, int'(map), int'(e.map));
`else
    if (map != e.map) ; // map only exists with the fail map build
`endif
  endtask

  task automatic check_cycle(string tag, int s, int lat, logic busy, logic done,
                             logic [1:0] a, logic [1:0] b);
    int rel;
    int be, de, abe;
    be = 0; de = 0; abe = 0;
    if (s >= 0) begin
      rel = cyc - s;
      be  = (rel >= 1 && rel <= N + lat) ? 1 : 0;
      de  = (rel == N + lat + 1) ? 1 : 0;
      abe = (rel >= 1 && rel <= N) ? rel - 1 : 0;
    end
    chk({tag, ".busy"}, int'(busy), be);
    chk({tag, ".done"}, int'(done), de);
    chk({tag, ".ab"}, int'({a, b}), abe);
  endtask

  // Monitor: per-cycle handshake checks plus scoreboard pop on each done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      check_cycle("u0", s0, 0, busy0, done0, a0, b0);
      check_cycle("u2", s2, 2, busy2, done2, a2, b2);
      if (done0) begin
        if (q0.size() == 0) chk("u0.unexpected_done", 1, 0);
        else check_res("u0", q0.pop_front(), err0, ffv0, ffab0, ffp0,
`ifdef FAIL_MAP_EN
                       map0
`else
                       16'h0
`endif
                       );
      end
      if (done2) begin
        if (q2.size() == 0) chk("u2.unexpected_done", 1, 0);
        else check_res("u2", q2.pop_front(), err2, ffv2, ffab2, ffp2,
`ifdef FAIL_MAP_EN
                       map2
`else
                       16'h0
`endif
                       );
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic sweep0(int mode, bit dly, bit repulse);
    mode0 = mode;
    dly0  = dly;
    tick(3 + $urandom_range(0, 3));
    last0 = model(mode, dly);
    q0.push_back(last0);
    start0 = 1'b1;
    s0 = cyc;
    tick(1);
    start0 = 1'b0;
    if (repulse) begin
      while (cyc < s0 + 3) tick(1);
      start0 = 1'b1; tick(1); start0 = 1'b0;
      while (cyc < s0 + 17) tick(1);
      start0 = 1'b1; tick(1); start0 = 1'b0;
    end
    while (cyc < s0 + N + 4) tick(1);
    chk("u0.queue_drained", q0.size(), 0);
    @(negedge clk);
    chk("u0.hold.err_count", int'(err0), int'(last0.err));
    chk("u0.hold.first_fail_ab", int'(ffab0), int'(last0.ffab));
    tick(1);
  endtask

  task automatic sweep2(int mode);
    mode2 = mode;
    tick(3 + $urandom_range(0, 3));
    q2.push_back(model(mode, 1'b0));
    start2 = 1'b1;
    s2 = cyc;
    tick(1);
    start2 = 1'b0;
    while (cyc < s2 + N + 6) tick(1);
    chk("u2.queue_drained", q2.size(), 0);
  endtask

  task automatic randomize_lut();
    for (int k = 0; k < N; k++) begin
      lut[k] = 4'((k / 4) * (k % 4));
      if ($urandom_range(0, 3) == 0) lut[k] = lut[k] ^ 4'($urandom_range(1, 15));
    end
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0;
    randomize_lut();
    tick(3);
    rst_n = 1'b1;
    tick(1);
    @(negedge clk);
    chk("reset.err_count", int'(err0), 0);
    chk("reset.first_fail_valid", int'(ffv0), 0);
    chk("reset.busy2", int'(busy2), 0);
    mon_en = 1;

    sweep0(0, 1'b0, 1'b0);   // exact multiplier
    sweep0(1, 1'b0, 1'b0);   // P tied to 0: 9 errors, map EEE0
    sweep0(2, 1'b0, 1'b0);   // P[0] stuck low: 4 errors, map A0A0
    sweep0(4, 1'b0, 1'b0);   // every vector wrong: count reaches N
    sweep2(0);               // registered-twice exact DUT, matched latency
    sweep0(0, 1'b1, 1'b0);   // same DUT, checker latency mismatched
    chk("latency_mismatch.nonzero", int'(err0 != 0), 1);
    sweep0(1, 1'b0, 1'b1);   // start re-pulsed mid-sweep and on done

    for (int i = 0; i < 6; i++) begin
      randomize_lut();
      sweep0(3, 1'b0, 1'b0);
      sweep2(3);
    end

    // Reset in cycle 6 of a sweep: outputs clear, no done, next sweep is clean.
    mode0 = 1;
    dly0 = 1'b0;
    tick(3);
    q0.push_back(model(1, 1'b0));
    start0 = 1'b1;
    s0 = cyc;
    tick(1);
    start0 = 1'b0;
    while (cyc < s0 + 6) tick(1);
    rst_n = 1'b0;
    tick(1);
    s0 = -1;
    q0.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset.err_count", int'(err0), 0);
    chk("midreset.first_fail_valid", int'(ffv0), 0);
    chk("midreset.first_fail_ab", int'(ffab0), 0);
    chk("midreset.first_fail_p", int'(ffp0), 0);
`ifdef FAIL_MAP_EN
    chk("midreset.fail_map", int'(map0), 0);
`endif
    tick(25);
    sweep0(2, 1'b0, 1'b0);

    tick(2);
    chk("end.q0_empty", q0.size(), 0);
    chk("end.q2_empty", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
